bbox_scheduler: RTL and testbench

Sequences one shared edge-search engine through four directional searches to get the tight bounding box of all set pixels inside a caller-supplied window. Each search after the first runs over a window narrowed by the earlier results. The block sits between the vision control logic (caller) and the edge searcher. It owns the searcher's start, direction and window inputs. It includes a watchdog that aborts a search that never finishes.

---
 rtl/bbox_pkg.sv | 27 ++
 rtl/search_watchdog.sv | 26 ++
 rtl/bbox_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_bbox_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared types and direction codes for the bounding-box scheduler and its
// searcher interface.
package bbox_pkg;

    localparam int COORD_W = 10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        P_TOP,
        P_BOTTOM,
        P_LEFT,
        P_RIGHT
    } phase_t;

endpackage

// File: rtl/search_watchdog.sv
// Clear/enable cycle counter that flags when a search has run for the
// maximum allowed number of cycles.
module search_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bbox_scheduler.sv
// Drives one shared edge searcher through top/bottom/left/right searches,
// narrowing the window after each hit, to find the tight bounding box.
module bbox_scheduler
    import bbox_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] win_x0,
    input  logic [9:0] win_y0,
    input  logic [9:0] win_x1,
    input  logic [9:0] win_y1,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic       error,
    output logic [9:0] bbox_x0,
    output logic [9:0] bbox_y0,
    output logic [9:0] bbox_x1,
    output logic [9:0] bbox_y1,
    output logic       search_start,
    output logic [1:0] search_dir,
    output logic [9:0] search_x0,
    output logic [9:0] search_y0,
    output logic [9:0] search_x1,
    output logic [9:0] search_y1,
    output logic       search_reset,
    input  logic       search_done,
    input  logic       search_found,
    input  logic [9:0] search_x,
    input  logic [9:0] search_y
);

    state_t state, state_next;
    phase_t phase;

    logic [9:0] wx0, wy0, wx1, wy1;
    logic [9:0] yt, yb, xl;
    logic       expired;
    logic       window_bad;
    logic       timeout;

    assign window_bad = (wx0 > wx1) || (wy0 > wy1);
    // A search_done in the expiry cycle takes priority over the watchdog.
    assign timeout    = (state == S_WAIT) && !search_done && expired;

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FINISH);
    assign search_start = (state == S_ISSUE);
    assign search_reset = timeout;

    search_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == S_ISSUE),
        .enable (state == S_WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_CHECK;
            S_CHECK:  state_next = window_bad ? S_FINISH : S_ISSUE;
            S_ISSUE:  state_next = S_WAIT;
            S_WAIT: begin
                if (search_done)
                    state_next = (!search_found || phase == P_RIGHT) ? S_FINISH : S_ISSUE;
                else if (expired)
                    state_next = S_FINISH;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Searcher window/direction are registered on entry to ISSUE so they hold
    // steady for the whole search.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= P_TOP;
            wx0        <= '0;
            wy0        <= '0;
            wx1        <= '0;
            wy1        <= '0;
            yt         <= '0;
            yb         <= '0;
            xl         <= '0;
            found      <= 1'b0;
            error      <= 1'b0;
            bbox_x0    <= '0;
            bbox_y0    <= '0;
            bbox_x1    <= '0;
            bbox_y1    <= '0;
            search_dir <= '0;
            search_x0  <= '0;
            search_y0  <= '0;
            search_x1  <= '0;
            search_y1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wx0     <= win_x0;
                        wy0     <= win_y0;
                        wx1     <= win_x1;
                        wy1     <= win_y1;
                        found   <= 1'b0;
                        error   <= 1'b0;
                        bbox_x0 <= '0;
                        bbox_y0 <= '0;
                        bbox_x1 <= '0;
                        bbox_y1 <= '0;
                        phase   <= P_TOP;
                    end
                end
                S_CHECK: begin
                    if (window_bad) begin
                        error <= 1'b1;
                    end else begin
                        search_dir <= DIR_DOWN;
                        search_x0  <= wx0;
                        search_y0  <= wy0;
                        search_x1  <= wx1;
                        search_y1  <= wy1;
                    end
                end
                S_WAIT: begin
                    if (search_done) begin
                        if (!search_found) begin
                            // A miss on the first search just means an empty window.
                            error <= (phase != P_TOP);
                        end else begin
                            case (phase)
                                P_TOP: begin
                                    yt         <= search_y;
                                    phase      <= P_BOTTOM;
                                    search_dir <= DIR_UP;
                                    search_x0  <= wx0;
                                    search_y0  <= search_y;
                                    search_x1  <= wx1;
                                    search_y1  <= wy1;
                                end
                                P_BOTTOM: begin
                                    yb         <= search_y;
                                    phase      <= P_LEFT;
                                    search_dir <= DIR_RIGHT;
                                    search_x0  <= wx0;
                                    search_y0  <= yt;
                                    search_x1  <= wx1;
                                    search_y1  <= search_y;
                                end
                                P_LEFT: begin
                                    xl         <= search_x;
                                    phase      <= P_RIGHT;
                                    search_dir <= DIR_LEFT;
                                    search_x0  <= search_x;
                                    search_y0  <= yt;
                                    search_x1  <= wx1;
                                    search_y1  <= yb;
                                end
                                P_RIGHT: begin
                                    bbox_x0 <= xl;
                                    bbox_y0 <= yt;
                                    bbox_x1 <= search_x;
                                    bbox_y1 <= yb;
                                    found   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end else if (expired) begin
                        error <= 1'b1;
                        found <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scheduler.sv
// Directed bench for bbox_scheduler with a behavioural edge searcher scanning
// a bit-packed image.
module tb_bbox_scheduler;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [9:0] win_x0, win_y0, win_x1, win_y1;
    logic       busy, done, found, error;
    logic [9:0] bbox_x0, bbox_y0, bbox_x1, bbox_y1;
    logic       search_start, search_reset;
    logic [1:0] search_dir;
    logic [9:0] search_x0, search_y0, search_x1, search_y1;
    logic       search_done, search_found;
    logic [9:0] search_x, search_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bbox_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
        .busy(busy), .done(done), .found(found), .error(error),
        .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
        .search_start(search_start), .search_dir(search_dir),
        .search_x0(search_x0), .search_y0(search_y0),
        .search_x1(search_x1), .search_y1(search_y1),
        .search_reset(search_reset), .search_done(search_done),
        .search_found(search_found), .search_x(search_x), .search_y(search_y)
    );

    // 32x32 image, 4 bytes per row, bit (x%8) of byte y*4 + x/8
    logic [7:0] img [0:127];
    int  latency = 1;
    bit  mute_up = 0;

    function automatic bit pix(input int x, input int y);
        logic [7:0] b;
        b = img[y*4 + x/8];
        return b[x%8];
    endfunction

    function automatic void scan(input logic [1:0] d, input int x0, input int y0,
                                 input int x1, input int y1,
                                 output bit f, output int sx, output int sy);
        f = 0; sx = 0; sy = 0;
        case (d)
            2'b01: for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++)
                       if (pix(x, y)) begin f = 1; sx = x; sy = y; return; end
            2'b00: for (int y = y1; y >= y0; y--) for (int x = x0; x <= x1; x++)
                       if (pix(x, y)) begin f = 1; sx = x; sy = y; return; end
            2'b11: for (int x = x0; x <= x1; x++) for (int y = y0; y <= y1; y++)
                       if (pix(x, y)) begin f = 1; sx = x; sy = y; return; end
            default: for (int x = x1; x >= x0; x--) for (int y = y0; y <= y1; y++)
                       if (pix(x, y)) begin f = 1; sx = x; sy = y; return; end
        endcase
    endfunction

    // searcher model: answers `latency` cycles after the search_start cycle
    initial begin : searcher
        int cnt, mx0, my0, mx1, my1, sx, sy;
        bit pending, f;
        logic [1:0] d;
        pending = 0; cnt = 0; d = 2'b00;
        mx0 = 0; my0 = 0; mx1 = 0; my1 = 0;
        search_done = 0; search_found = 0; search_x = 0; search_y = 0;
        forever begin
            @(posedge clk); #1;
            search_done = 0;
            if (reset) begin
                pending = 0;
            end else if (search_start) begin
                pending = 1; cnt = latency; d = search_dir;
                mx0 = int'(search_x0); my0 = int'(search_y0);
                mx1 = int'(search_x1); my1 = int'(search_y1);
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending = 0;
                    if (!(mute_up && d == 2'b00)) begin
                        scan(d, mx0, my0, mx1, my1, f, sx, sy);
                        search_done = 1; search_found = f;
                        search_x = 10'(sx); search_y = 10'(sy);
                    end
                end
            end
        end
    end

    int n_start = 0, n_sreset = 0;
    logic [1:0]  log_dir [0:63];
    logic [39:0] log_win [0:63];

    always @(negedge clk) begin
        if (search_start) begin
            log_dir[n_start % 64] = search_dir;
            log_win[n_start % 64] = {search_x0, search_y0, search_x1, search_y1};
            n_start++;
        end
        if (search_reset) n_sreset++;
    end

    task automatic pulse_start(input int x0, input int y0, input int x1, input int y1);
        win_x0 = 10'(x0); win_y0 = 10'(y0); win_x1 = 10'(x1); win_y1 = 10'(y1);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (done) ok = 1;
        end
    endtask

    task automatic test_reset;
        reset = 1; start = 0;
        win_x0 = 0; win_y0 = 0; win_x1 = 0; win_y1 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, found, error, search_start, search_reset} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, found, error, search_start, search_reset});
        end
        checks++;
        if ({bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== 40'h0) begin
            errors++;
            $display("FAIL reset_bbox: got %h expected 0", {bbox_x0, bbox_y0, bbox_x1, bbox_y1});
        end
        checks++;
        if ({search_dir, search_x0, search_y0, search_x1, search_y1} !== 42'h0) begin
            errors++;
            $display("FAIL reset_search: got %h expected 0",
                     {search_dir, search_x0, search_y0, search_x1, search_y1});
        end
        reset = 0;
    endtask

    task automatic test_bbox;
        int base;
        bit ok;
        logic [1:0]  exp_dir [4];
        logic [39:0] exp_win [4];
        exp_dir[0] = 2'b01; exp_dir[1] = 2'b00; exp_dir[2] = 2'b11; exp_dir[3] = 2'b10;
        exp_win[0] = {10'd2, 10'd2, 10'd10, 10'd10};
        exp_win[1] = {10'd2, 10'd2, 10'd10, 10'd10};
        exp_win[2] = {10'd2, 10'd2, 10'd10, 10'd5};
        exp_win[3] = {10'd3, 10'd2, 10'd10, 10'd5};
        latency = 2;
        base = n_start;
        pulse_start(2, 2, 10, 10);
        checks++;
        if (busy !== 1'b1 || search_start !== 1'b0) begin
            errors++;
            $display("FAIL bbox_k1: busy=%b search_start=%b expected 1 0", busy, search_start);
        end
        @(posedge clk); #1;
        checks++;
        if (search_start !== 1'b1 || search_dir !== 2'b01) begin
            errors++;
            $display("FAIL bbox_k2_issue: start=%b dir=%b expected 1 01", search_start, search_dir);
        end
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bbox_done: no done within 200 cycles"); end
        checks++;
        if ({found, error} !== 2'b10) begin
            errors++;
            $display("FAIL bbox_flags: got found/error %b expected 10", {found, error});
        end
        checks++;
        if ({bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== {10'd3, 10'd2, 10'd9, 10'd5}) begin
            errors++;
            $display("FAIL bbox_value: got %0d,%0d-%0d,%0d expected 3,2-9,5",
                     bbox_x0, bbox_y0, bbox_x1, bbox_y1);
        end
        checks++;
        if (n_start - base !== 4) begin
            errors++;
            $display("FAIL bbox_starts: got %0d expected 4", n_start - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_dir[(base + i) % 64] !== exp_dir[i] || log_win[(base + i) % 64] !== exp_win[i]) begin
                errors++;
                $display("FAIL bbox_search%0d: got dir %b win %h expected dir %b win %h", i,
                         log_dir[(base + i) % 64], log_win[(base + i) % 64], exp_dir[i], exp_win[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, found} !== 3'b001) begin
            errors++;
            $display("FAIL bbox_after: done/busy/found %b expected 001", {done, busy, found});
        end
    endtask

    task automatic test_empty;
        int base;
        bit ok;
        base = n_start;
        pulse_start(11, 6, 15, 10);
        wait_done(100, ok);
        checks++;
        if (!ok || {found, error} !== 2'b00 || n_start - base !== 1) begin
            errors++;
            $display("FAIL empty: done=%b found/error %b starts %0d expected 1 00 1",
                     ok, {found, error}, n_start - base);
        end
        checks++;
        if ({bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== 40'h0) begin
            errors++;
            $display("FAIL empty_bbox_cleared: got %h expected 0", {bbox_x0, bbox_y0, bbox_x1, bbox_y1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid;
        int base;
        base = n_start;
        pulse_start(10, 2, 2, 10);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL invalid_k1: busy=%b done=%b expected 1 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || {found, error} !== 2'b01) begin
            errors++;
            $display("FAIL invalid_k2: done=%b found/error %b expected 1 01", done, {found, error});
        end
        @(posedge clk); #1;
        checks++;
        if (n_start - base !== 0 || busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL invalid_after: starts %0d busy %b error %b expected 0 0 1",
                     n_start - base, busy, error);
        end
    endtask

    task automatic test_timeout;
        int base, rbase;
        bit ok;
        latency = 2; mute_up = 1;
        base = n_start; rbase = n_sreset;
        pulse_start(2, 2, 10, 10);
        wait_done(100, ok);
        checks++;
        if (!ok || {found, error} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_flags: done=%b found/error %b expected 1 01", ok, {found, error});
        end
        checks++;
        if (n_sreset - rbase !== 1 || n_start - base !== 2) begin
            errors++;
            $display("FAIL timeout_pulses: search_reset %0d starts %0d expected 1 2",
                     n_sreset - rbase, n_start - base);
        end
        mute_up = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_done_wins;
        int rbase;
        bit ok;
        latency = 16;
        rbase = n_sreset;
        pulse_start(2, 2, 10, 10);
        wait_done(300, ok);
        checks++;
        if (!ok || {found, error} !== 2'b10 || n_sreset - rbase !== 0) begin
            errors++;
            $display("FAIL done_wins: done=%b found/error %b resets %0d expected 1 10 0",
                     ok, {found, error}, n_sreset - rbase);
        end
        checks++;
        if ({bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== {10'd3, 10'd2, 10'd9, 10'd5}) begin
            errors++;
            $display("FAIL done_wins_bbox: got %0d,%0d-%0d,%0d expected 3,2-9,5",
                     bbox_x0, bbox_y0, bbox_x1, bbox_y1);
        end
        latency = 2;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_then_reset;
        int base;
        bit ok, hit;
        latency = 2;
        base = n_start;
        pulse_start(2, 2, 10, 10);
        @(posedge clk); #1;
        pulse_start(0, 0, 1, 1);
        wait_done(200, ok);
        checks++;
        if (!ok || {found, error} !== 2'b10 || n_start - base !== 4 ||
            {bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== {10'd3, 10'd2, 10'd9, 10'd5}) begin
            errors++;
            $display("FAIL busy_start: done=%b f/e %b starts %0d bbox %0d,%0d-%0d,%0d expected 1 10 4 3,2-9,5",
                     ok, {found, error}, n_start - base, bbox_x0, bbox_y0, bbox_x1, bbox_y1);
        end
        @(posedge clk); #1;
        base = n_start;
        pulse_start(2, 2, 10, 10);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (n_start - base >= 3) hit = 1;
        end
        checks++;
        if (!hit || busy !== 1'b1) begin
            errors++;
            $display("FAIL reach_p2_wait: reached=%b busy=%b expected 1 1", hit, busy);
        end
        reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, found, error, search_start, search_reset} !== 6'b0 ||
            {bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== 40'h0 ||
            {search_dir, search_x0, search_y0, search_x1, search_y1} !== 42'h0) begin
            errors++;
            $display("FAIL mid_reset: ctrl %b bbox %h search %h expected all 0",
                     {busy, done, found, error, search_start, search_reset},
                     {bbox_x0, bbox_y0, bbox_x1, bbox_y1},
                     {search_dir, search_x0, search_y0, search_x1, search_y1});
        end
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        base = n_start;
        pulse_start(2, 2, 10, 10);
        wait_done(200, ok);
        checks++;
        if (!ok || {found, error} !== 2'b10 || n_start - base !== 4 ||
            {bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== {10'd3, 10'd2, 10'd9, 10'd5}) begin
            errors++;
            $display("FAIL after_reset_run: done=%b f/e %b starts %0d bbox %0d,%0d-%0d,%0d expected 1 10 4 3,2-9,5",
                     ok, {found, error}, n_start - base, bbox_x0, bbox_y0, bbox_x1, bbox_y1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_pixel;
        bit ok;
        pulse_start(7, 2, 7, 2);
        wait_done(100, ok);
        checks++;
        if (!ok || {found, error} !== 2'b10 ||
            {bbox_x0, bbox_y0, bbox_x1, bbox_y1} !== {10'd7, 10'd2, 10'd7, 10'd2}) begin
            errors++;
            $display("FAIL single_pixel: done=%b f/e %b bbox %0d,%0d-%0d,%0d expected 1 10 7,2-7,2",
                     ok, {found, error}, bbox_x0, bbox_y0, bbox_x1, bbox_y1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) img[i] = 8'h00;
        img[2*4 + 0][7] = 1'b1;
        img[3*4 + 0][3] = 1'b1;
        img[4*4 + 1][1] = 1'b1;
        img[5*4 + 0][5] = 1'b1;
        test_reset();
        test_bbox();
        test_empty();
        test_invalid();
        test_timeout();
        test_done_wins();
        test_busy_then_reset();
        test_single_pixel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
